csb_master_arbiter: RTL and testbench

Parametrised N-to-1 CSB request arbiter with in-order response routing. Sits between several CSB request sources (bench drivers, firmware-model ports or the host bridge) and a single CSB target such as the NVDLA register interface. It round-robins requests onto one CSB port, tracks every request that expects a response in an order FIFO, and steers each `rvld`/`wr_complete` back to the originating source. Posted writes complete at handshake and produce no return traffic.

---
 rtl/csb_master_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_csb_master_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csb_master_arbiter.sv
// csb_master_arbiter: round-robin N-to-1 CSB request arbiter with an order FIFO
// that routes read data and non-posted write completions back to the source
// that issued the request. Posted writes retire at the target handshake.
module csb_master_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS-1:0]                 m_pvld,
  output logic [NUM_MASTERS-1:0]                 m_prdy,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr,
  input  logic [NUM_MASTERS-1:0]                 m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wdata,
  input  logic [NUM_MASTERS-1:0]                 m_nposted,
  output logic [NUM_MASTERS-1:0]                 m_rvld,
  output logic [DATA_WIDTH-1:0]                  m_rdata,
  output logic [NUM_MASTERS-1:0]                 m_wr_complete,
  output logic                                   tgt_pvld,
  output logic [ADDR_WIDTH-1:0]                  tgt_addr,
  output logic                                   tgt_write,
  output logic [DATA_WIDTH-1:0]                  tgt_wdata,
  output logic                                   tgt_nposted,
  input  logic                                   tgt_prdy,
  input  logic                                   tgt_rvld,
  input  logic [DATA_WIDTH-1:0]                  tgt_rdata,
  input  logic                                   tgt_wr_complete,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   resp_err
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // Order-FIFO pointer advance, wrapping at the FIFO depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin pointer advance, wrapping at the source count
  function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_MASTERS - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  logic                   vld_p1;
  logic [ADDR_WIDTH-1:0]  addr_p1;
  logic                   write_p1;
  logic [DATA_WIDTH-1:0]  wdata_p1;
  logic                   nposted_p1;

  logic [IDX_W-1:0]       rr_ptr;
  logic                   can_cap;
  logic                   room;
  logic [NUM_MASTERS-1:0] elig;
  logic                   gnt_vld;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       cand;
  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic                   cap_write;
  logic [DATA_WIDTH-1:0]  cap_wdata;
  logic                   cap_nposted;

  logic [IDX_W-1:0]       fifo_src [MAX_OUTSTANDING];
  logic                   fifo_rd  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic                   push;
  logic                   pop;
  logic                   rsp_any;
  logic                   fifo_empty;
  logic [IDX_W-1:0]       head_src;
  logic                   head_rd;

  assign tgt_pvld    = vld_p1;
  assign tgt_addr    = addr_p1;
  assign tgt_write   = write_p1;
  assign tgt_wdata   = wdata_p1;
  assign tgt_nposted = nposted_p1;

  // The ORR can take a new request when empty or draining this cycle; the
  // room test uses occupancy before any same-cycle pop.
  assign can_cap    = !vld_p1 || tgt_prdy;
  assign room       = outstanding < OUT_W'(MAX_OUTSTANDING);
  assign fifo_empty = (outstanding == '0);
  assign rsp_any    = tgt_rvld || tgt_wr_complete;
  assign pop        = rsp_any && !fifo_empty;
  assign push       = gnt_vld && (!cap_write || cap_nposted);
  assign head_src   = fifo_src[rd_ptr];
  assign head_rd    = fifo_rd[rd_ptr];

  // Eligibility: posted writes bypass the FIFO-room check
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_pvld[i] && (room || (m_write[i] && !m_nposted[i]));
    end
  end

  // Round-robin search from rr_ptr; no grant while in reset
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_n && can_cap) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
        if (!gnt_vld && elig[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Winner decode: one-hot accept plus the winner's request fields
  always_comb begin
    m_prdy      = '0;
    cap_addr    = '0;
    cap_write   = 1'b0;
    cap_wdata   = '0;
    cap_nposted = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
        m_prdy[i]   = 1'b1;
        cap_addr    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        cap_write   = m_write[i];
        cap_wdata   = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        cap_nposted = m_nposted[i];
      end
    end
  end

  // ---- stage p1: output request register toward the target ----
  // Load on grant, otherwise empty after the target handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      write_p1   <= 1'b0;
      wdata_p1   <= '0;
      nposted_p1 <= 1'b0;
    end else if (gnt_vld) begin
      vld_p1     <= 1'b1;
      addr_p1    <= cap_addr;
      write_p1   <= cap_write;
      wdata_p1   <= cap_wdata;
      nposted_p1 <= cap_nposted;
    end else if (tgt_prdy) begin
      vld_p1     <= 1'b0;
    end
  end

  // Round-robin pointer moves past each winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= rr_inc(gnt_idx);
    end
  end

  // Order-FIFO storage: {source, is_read} for each response-bearing request
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr] <= gnt_idx;
      fifo_rd[wr_ptr]  <= !cap_write;
    end
  end

  // Order-FIFO pointers and occupancy; push and pop together cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      outstanding <= outstanding + OUT_W'(1);
      else if (pop && !push) outstanding <= outstanding - OUT_W'(1);
    end
  end

  // ---- stage p2: response routing back to the head source ----
  // A read response wins if both response strobes arrive together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_rvld        <= '0;
      m_wr_complete <= '0;
      m_rdata       <= '0;
    end else begin
      m_rvld        <= '0;
      m_wr_complete <= '0;
      if (pop) begin
        if (tgt_rvld) begin
          m_rvld[head_src] <= 1'b1;
          m_rdata          <= tgt_rdata;
        end else begin
          m_wr_complete[head_src] <= 1'b1;
        end
      end
    end
  end

  // Sticky error: response with nothing pending, type mismatch, or both strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_err <= 1'b0;
    end else if (rsp_any && (fifo_empty || (tgt_rvld && tgt_wr_complete) ||
                             (tgt_rvld != head_rd))) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csb_master_arbiter.sv
// tb_csb_master_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue-based behavioural model of the arbiter.
module tb_csb_master_arbiter;

  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_pvld, m_prdy, m_write, m_nposted, m_rvld, m_wr_complete;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            tgt_pvld, tgt_write, tgt_nposted, tgt_prdy, tgt_rvld, tgt_wr_complete;
  logic [AW-1:0]   tgt_addr;
  logic [DW-1:0]   tgt_wdata, tgt_rdata;
  logic [OW-1:0]   outstanding;
  logic            resp_err;

  always #5 clk = ~clk;

  csb_master_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_pvld(m_pvld), .m_prdy(m_prdy), .m_addr(m_addr), .m_write(m_write),
    .m_wdata(m_wdata), .m_nposted(m_nposted), .m_rvld(m_rvld), .m_rdata(m_rdata),
    .m_wr_complete(m_wr_complete),
    .tgt_pvld(tgt_pvld), .tgt_addr(tgt_addr), .tgt_write(tgt_write),
    .tgt_wdata(tgt_wdata), .tgt_nposted(tgt_nposted), .tgt_prdy(tgt_prdy),
    .tgt_rvld(tgt_rvld), .tgt_rdata(tgt_rdata), .tgt_wr_complete(tgt_wr_complete),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  int checks = 0;
  int errors = 0;

  // source-side pending requests (held until accepted)
  logic          pend_v  [N];
  logic          pend_w  [N];
  logic          pend_np [N];
  logic [AW-1:0] pend_a  [N];
  logic [DW-1:0] pend_d  [N];

  // behavioural model: queue entries are src*2 + is_read
  int            q[$];
  int            rr;
  logic          mo_v, mo_w, mo_np;
  logic [AW-1:0] mo_a;
  logic [DW-1:0] mo_d;
  logic [N-1:0]  e_rvld, e_wrc;
  logic [DW-1:0] e_rdata;
  logic          e_err;
  int            e_gnt;
  logic [N-1:0]  obs_prdy;
  int            gnt_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit w, input bit np,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_v[i] = 1'b1; pend_w[i] = w; pend_np[i] = np; pend_a[i] = a; pend_d[i] = d;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    tgt_prdy = 1'b1; tgt_rvld = 1'b0; tgt_wr_complete = 1'b0; tgt_rdata = '0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      m_pvld[i]    = pend_v[i];
      m_write[i]   = pend_w[i];
      m_nposted[i] = pend_np[i];
      m_addr[i*AW +: AW]  = pend_a[i];
      m_wdata[i*DW +: DW] = pend_d[i];
    end
  endtask

  // Target responds correctly to the head of the model queue
  task automatic auto_respond(input bit en);
    tgt_rvld = 1'b0; tgt_wr_complete = 1'b0;
    tgt_rdata = $urandom;
    if (en && q.size() > 0) begin
      if (q[0] % 2 == 1) tgt_rvld = 1'b1;
      else               tgt_wr_complete = 1'b1;
    end
  endtask

  task automatic compare_all();
    bit can, room, found;
    logic [N-1:0] ev;
    can   = !mo_v || tgt_prdy;
    room  = q.size() < MAXO;
    found = 1'b0;
    e_gnt = -1;
    if (rst_n && can) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (!found && pend_v[i] && (room || (pend_w[i] && !pend_np[i]))) begin
          found = 1'b1;
          e_gnt = i;
        end
      end
    end
    ev = '0;
    if (e_gnt >= 0) ev[e_gnt] = 1'b1;
    obs_prdy = m_prdy;
    for (int i = 0; i < N; i++) if (m_prdy[i] === 1'b1) gnt_log.push_back(i);
    chk("m_prdy", m_prdy, ev);
    chk("tgt_pvld", tgt_pvld, mo_v);
    chk("tgt_addr", tgt_addr, mo_a);
    chk("tgt_wdata", tgt_wdata, mo_d);
    chk("tgt_write", tgt_write, mo_w);
    chk("tgt_nposted", tgt_nposted, mo_np);
    chk("m_rvld", m_rvld, e_rvld);
    chk("m_wr_complete", m_wr_complete, e_wrc);
    chk("m_rdata", m_rdata, e_rdata);
    chk("outstanding", outstanding, q.size());
    chk("resp_err", resp_err, e_err);
  endtask

  task automatic model_update();
    if (!rst_n) begin
      q.delete(); rr = 0;
      mo_v = 0; mo_w = 0; mo_np = 0; mo_a = '0; mo_d = '0;
      e_rvld = '0; e_wrc = '0; e_rdata = '0; e_err = 0;
    end else begin
      e_rvld = '0; e_wrc = '0;
      if (tgt_rvld || tgt_wr_complete) begin
        if (q.size() == 0) e_err = 1'b1;
        else begin
          int ent, h, t;
          ent = q.pop_front();
          h = ent / 2; t = ent % 2;
          if (tgt_rvld && tgt_wr_complete) e_err = 1'b1;
          if (tgt_rvld) begin
            e_rvld[h] = 1'b1; e_rdata = tgt_rdata;
            if (t == 0) e_err = 1'b1;
          end else begin
            e_wrc[h] = 1'b1;
            if (t == 1) e_err = 1'b1;
          end
        end
      end
      if (e_gnt >= 0) begin
        mo_v = 1'b1; mo_a = pend_a[e_gnt]; mo_d = pend_d[e_gnt];
        mo_w = pend_w[e_gnt]; mo_np = pend_np[e_gnt];
        rr = (e_gnt + 1) % N;
        if (!pend_w[e_gnt] || pend_np[e_gnt]) q.push_back(e_gnt * 2 + (pend_w[e_gnt] ? 0 : 1));
        pend_v[e_gnt] = 1'b0;
      end else if (tgt_prdy) begin
        mo_v = 1'b0;
      end
    end
  endtask

  task automatic tick();
    apply_inputs();
    #1;
    compare_all();
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 0; pend_w[i] = 0; pend_np[i] = 0; pend_a[i] = '0; pend_d[i] = '0;
    end
    clear_inputs();
    apply_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_update();
    rst_n = 1'b1;
    // reset state
    chk("rst_tgt_pvld", tgt_pvld, 1'b0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_m_rdata", m_rdata, 0);

    // single read from source 2
    set_req(2, 0, 0, 16'h0040, 32'h0);
    tick();
    chk("sr_grant", obs_prdy, 4'b0100);
    chk("sr_tgt_pvld", tgt_pvld, 1'b1);
    chk("sr_tgt_addr", tgt_addr, 16'h0040);
    chk("sr_out1", outstanding, 1);
    repeat (3) tick();
    tgt_rvld = 1'b1; tgt_rdata = 32'hDEADBEEF;
    tick();
    tgt_rvld = 1'b0;
    chk("sr_rvld", m_rvld, 4'b0100);
    chk("sr_rdata", m_rdata, 32'hDEADBEEF);
    chk("sr_out0", outstanding, 0);
    tick();

    // round-robin with continuous reads and immediate responses
    do_reset();
    gnt_log.delete();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) set_req(i, 0, 0, AW'(i * 4), 32'h0);
      auto_respond(1);
      tick();
    end
    chk("rr_count", gnt_log.size(), 10);
    if (gnt_log.size() >= 6)
      for (int k = 0; k < 6; k++) chk("rr_order", gnt_log[k], k % N);

    // FIFO full: read stalls, posted write passes
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 0, 0, AW'(16'h100 + i), 32'h0);
    repeat (4) tick();
    chk("ff_out4", outstanding, 4);
    set_req(0, 0, 0, 16'h0200, 32'h0);
    set_req(1, 1, 0, 16'h0300, 32'h12345678);
    tick();
    chk("ff_posted", obs_prdy, 4'b0010);
    tick();
    chk("ff_stall", obs_prdy, 4'b0000);
    tgt_rvld = 1'b1; tgt_rdata = 32'h0BADF00D;
    tick();
    chk("ff_samecyc", obs_prdy, 4'b0000);
    tgt_rvld = 1'b0;
    tick();
    chk("ff_granted", obs_prdy, 4'b0001);
    for (int c = 0; c < 8; c++) begin auto_respond(1); tick(); end
    auto_respond(0);

    // back-pressure on a non-posted write
    do_reset();
    tgt_prdy = 1'b0;
    set_req(3, 1, 1, 16'h1234, 32'hCAFE0001);
    tick();
    set_req(1, 0, 0, 16'h0010, 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_addr", tgt_addr, 16'h1234);
      chk("bp_wdata", tgt_wdata, 32'hCAFE0001);
      chk("bp_noprdy", obs_prdy, 4'b0000);
    end
    tgt_prdy = 1'b1;
    tick();
    chk("bp_next", obs_prdy, 4'b0010);
    tgt_wr_complete = 1'b1;
    tick();
    tgt_wr_complete = 1'b0;
    chk("bp_wrc", m_wr_complete, 4'b1000);
    tgt_rvld = 1'b1; tgt_rdata = 32'h55AA55AA;
    tick();
    tgt_rvld = 1'b0;
    chk("bp_rvld", m_rvld, 4'b0010);

    // protocol error 1: response with nothing outstanding
    do_reset();
    tgt_rvld = 1'b1;
    tick();
    tgt_rvld = 1'b0;
    chk("pe1_err", resp_err, 1'b1);
    chk("pe1_norvld", m_rvld, 4'b0000);
    // protocol error 2: write completion against a read head
    do_reset();
    chk("pe2_clr", resp_err, 1'b0);
    set_req(2, 0, 0, 16'h0044, 32'h0);
    repeat (2) tick();
    tgt_wr_complete = 1'b1;
    tick();
    tgt_wr_complete = 1'b0;
    chk("pe2_route", m_wr_complete, 4'b0100);
    chk("pe2_err", resp_err, 1'b1);
    repeat (3) tick();
    chk("pe2_sticky", resp_err, 1'b1);
    do_reset();
    chk("pe2_rst", resp_err, 1'b0);

    // mid-operation reset with three outstanding and the ORR full
    for (int i = 0; i < 3; i++) set_req(i, 0, 0, AW'(16'h0500 + i), 32'h0);
    repeat (3) tick();
    tgt_prdy = 1'b0;
    tick();
    chk("mr_out3", outstanding, 3);
    chk("mr_orr", tgt_pvld, 1'b1);
    do_reset();
    chk("mr_pvld0", tgt_pvld, 1'b0);
    chk("mr_out0", outstanding, 0);
    chk("mr_addr0", tgt_addr, 0);
    tgt_rvld = 1'b1;
    tick();
    tgt_rvld = 1'b0;
    chk("mr_late", resp_err, 1'b1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(99) < 60)
          set_req(i, 1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom), $urandom);
      tgt_prdy = ($urandom_range(99) < 70);
      auto_respond($urandom_range(99) < 40);
      if ($urandom_range(999) < 5) begin
        tgt_rvld = 1'($urandom_range(1));
        tgt_wr_complete = 1'($urandom_range(1));
      end
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        tick();
      end
    end
    clear_inputs();
    for (int c = 0; c < 12; c++) begin auto_respond(1); tick(); end
    auto_respond(0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
